// File: rtl/qtz_pkg.sv
// rtl/qtz_pkg.sv - shared sizing constants and FSM state type for the chunk collector
package qtz_pkg;

    localparam int FEATURE_COUNT    = 617;
    localparam int FEATURES_PER_CC  = 155;
    localparam int CHUNK_COUNT      = 4;
    localparam int LAST_CHUNK_LANES = 152;

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_FULL    = 1'b1
    } state_t;

endpackage

// File: rtl/qtz_chunk_collect.sv
// rtl/qtz_chunk_collect.sv - reassembles 4 feature chunks into one vector; QTZ_PAD_CHECK_EN adds sticky pad_err
module qtz_chunk_collect
    import qtz_pkg::state_t, qtz_pkg::ST_COLLECT, qtz_pkg::ST_FULL;
#(
    parameter int FEATURE_COUNT   = qtz_pkg::FEATURE_COUNT,
    parameter int FEATURES_PER_CC = qtz_pkg::FEATURES_PER_CC
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [16*FEATURES_PER_CC-1:0] in_chunk,
    output logic [1:0]                    chunk_idx,
`ifdef QTZ_PAD_CHECK_EN
    output logic                          pad_err,
`endif
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [16*FEATURE_COUNT-1:0]   out_vec
);

    localparam int         CHUNKS     = (FEATURE_COUNT + FEATURES_PER_CC - 1) / FEATURES_PER_CC;
    localparam int         LAST_LANES = FEATURE_COUNT - (CHUNKS - 1) * FEATURES_PER_CC;
    localparam logic [1:0] LAST_IDX   = 2'(CHUNKS - 1);

    state_t state;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= ST_COLLECT;
            chunk_idx <= 2'd0;
            out_vec   <= '0;
`ifdef QTZ_PAD_CHECK_EN
            pad_err   <= 1'b0;
`endif
        end else if (flush) begin
            // Abort drops the partial vector but keeps out_vec contents.
            state     <= ST_COLLECT;
            chunk_idx <= 2'd0;
`ifdef QTZ_PAD_CHECK_EN
            pad_err   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_COLLECT: begin
                    if (in_valid) begin
                        for (int c = 0; c < CHUNKS; c++) begin
                            if (chunk_idx == 2'(c)) begin
                                // Lanes past the end of the vector are padding.
                                for (int l = 0; l < FEATURES_PER_CC; l++) begin
                                    if (c * FEATURES_PER_CC + l < FEATURE_COUNT)
                                        out_vec[(c*FEATURES_PER_CC+l)*16 +: 16] <= in_chunk[l*16 +: 16];
                                end
                            end
                        end
                        if (chunk_idx == LAST_IDX) begin
                            chunk_idx <= 2'd0;
                            state     <= ST_FULL;
`ifdef QTZ_PAD_CHECK_EN
                            if (|in_chunk[16*FEATURES_PER_CC-1 : 16*LAST_LANES])
                                pad_err <= 1'b1;
`endif
                        end else begin
                            chunk_idx <= chunk_idx + 2'd1;
                        end
                    end
                end
                ST_FULL: begin
                    if (out_ready)
                        state <= ST_COLLECT;
                end
                default: state <= ST_COLLECT;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == ST_COLLECT);
        out_valid = (state == ST_FULL);
    end

endmodule
